// File: rtl/neo_pkg.sv
// Shared types, default timing and the brightness scaler for the NeoPixel strand controller.
// Latency: none (package only).
// Backpressure: none (package only).
package neo_pkg;

    typedef enum logic [1:0] {
        COLOR_G = 2'd0,
        COLOR_R = 2'd1,
        COLOR_B = 2'd2,
        COLOR_W = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // WS2812 timing at a 50 MHz clock
    localparam int DEF_T0H_CYC    = 18;    // 0.35 us
    localparam int DEF_T1H_CYC    = 35;    // 0.70 us
    localparam int DEF_TBIT_CYC   = 63;    // 1.25 us
    localparam int DEF_TRESET_CYC = 2500;  // 50 us

    // Global brightness: 255 is identity, 0 blanks the byte
    function automatic logic [7:0] scale_level(input logic [7:0] level, input logic [7:0] bright);
        logic [15:0] w_prod;
        w_prod = {8'd0, level} * ({8'd0, bright} + 16'd1);
        return w_prod[15:8];
    endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// One-bit WS2812 waveform generator: line high for T0H/T1H cycles, low for the rest of TBIT_CYC.
// Latency: line goes high on the edge that samples start; bit_done marks the last cycle of the bit.
// Backpressure: none; a start in the bit_done cycle chains the next bit with no gap.
module neo_bit_encoder #(
    parameter int T0H_CYC  = 18,
    parameter int T1H_CYC  = 35,
    parameter int TBIT_CYC = 63
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic line,
    output logic bit_done
);
    localparam int CW = $clog2(TBIT_CYC);
    localparam logic [CW:0] HI0 = (CW+1)'(T0H_CYC);
    localparam logic [CW:0] HI1 = (CW+1)'(T1H_CYC);

    logic [CW-1:0] r_cnt;
    logic          r_val;
    logic          r_act;
    logic          r_line;
    logic [CW:0]   w_next;
    logic [CW:0]   w_hi;

    assign w_next   = {1'b0, r_cnt} + (CW+1)'(1);
    assign w_hi     = r_val ? HI1 : HI0;
    assign bit_done = r_act && (r_cnt == CW'(TBIT_CYC - 1));
    assign line     = r_line;

    // Bit-period counter and registered line level (high while count is below the high time)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_val  <= 1'b0;
            r_act  <= 1'b0;
            r_line <= 1'b0;
        end else if (start) begin
            r_cnt  <= '0;
            r_val  <= bit_val;
            r_act  <= 1'b1;
            r_line <= 1'b1;
        end else if (bit_done) begin
            r_cnt  <= '0;
            r_act  <= 1'b0;
            r_line <= 1'b0;
        end else if (r_act) begin
            r_cnt  <= w_next[CW-1:0];
            r_line <= (w_next < w_hi);
        end
    end

endmodule

// File: rtl/neo_strand_ctrl_param.sv
// WS2812 strand controller: colour store for NUM_PIXELS x NUM_COLORS bytes, serialised G,R,B(,W) MSB-first.
// Latency: first bit high phase starts the cycle after send_it acceptance; busy NBITS*TBIT_CYC+TRESET_CYC cycles.
// Backpressure: ready_to_load/ready_to_send high only in IDLE, requests otherwise dropped; NEO_BRIGHTNESS_EN adds brightness.
module neo_strand_ctrl_param
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int NUM_COLORS = 3,
    parameter int T0H_CYC    = DEF_T0H_CYC,
    parameter int T1H_CYC    = DEF_T1H_CYC,
    parameter int TBIT_CYC   = DEF_TBIT_CYC,
    parameter int TRESET_CYC = DEF_TRESET_CYC
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pixel_index,
    input  logic [1:0]                                             color_index,
    input  logic [7:0]                                             color_level,
    input  logic                                                   load_color,
    input  logic                                                   send_it,
`ifdef NEO_BRIGHTNESS_EN
    input  logic [7:0]                                             brightness,
`endif
    output logic                                                   neo_data,
    output logic                                                   ready_to_load,
    output logic                                                   ready_to_send
);
    localparam int NB    = NUM_PIXELS * NUM_COLORS;
    localparam int NBITS = NB * 8;
    localparam int AW    = $clog2(NB);
    localparam int BW    = $clog2(NBITS);
    localparam int LW    = $clog2(TRESET_CYC + 1);

    if (NUM_COLORS != 3 && NUM_COLORS != 4) begin : g_bad_colors
        $error("neo_strand_ctrl_param: NUM_COLORS must be 3 or 4");
    end
    if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
        $error("neo_strand_ctrl_param: need T0H_CYC < T1H_CYC < TBIT_CYC");
    end

    state_t        r_state;
    logic          r_rdy;
    logic [BW-1:0] r_bit_idx;
    logic [LW-1:0] r_lat_cnt;
    logic [7:0]    r_mem [NB];

    logic          w_load_ok;
    logic          w_accept;
    logic          w_bit_done;
    logic          w_last_bit;
    logic          w_enc_start;
    logic          w_bit_val;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [BW-1:0] w_nxt_idx;
    logic [7:0]    w_raw_byte;
    logic [7:0]    w_tx_byte;

    assign w_load_ok = load_color && (r_state == IDLE)
                     && (int'(pixel_index) < NUM_PIXELS) && (int'(color_index) < NUM_COLORS);
    assign w_wr_addr = AW'(int'(pixel_index) * NUM_COLORS + int'(color_index));
    assign w_accept  = send_it && (r_state == IDLE);
    assign w_last_bit = (r_bit_idx == BW'(NBITS - 1));

    // Bit index that the encoder starts next: 0 on acceptance, else the one after the current bit.
    // Byte order on the wire is simply the linear storage order pixel*NUM_COLORS+colour.
    assign w_nxt_idx = (r_state == IDLE) ? '0 : r_bit_idx + BW'(1);
    assign w_rd_addr = w_nxt_idx[BW-1:3];

    // A load into byte 0 in the acceptance cycle is forwarded so the new byte leads the frame
    assign w_raw_byte = (w_load_ok && (w_wr_addr == '0)) ? color_level : r_mem[w_rd_addr];

`ifdef NEO_BRIGHTNESS_EN
    logic [7:0] r_bright;
    logic [7:0] w_bright;
    assign w_bright  = (r_state == IDLE) ? brightness : r_bright;
    assign w_tx_byte = scale_level(w_raw_byte, w_bright);

    // Brightness is frozen at acceptance so mid-frame changes cannot tear the frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bright <= 8'hFF;
        end else if (w_accept) begin
            r_bright <= brightness;
        end
    end
`else
    assign w_tx_byte = w_raw_byte;
`endif

    assign w_bit_val   = w_tx_byte[3'd7 - w_nxt_idx[2:0]];
    assign w_enc_start = w_accept || ((r_state == SEND) && w_bit_done && !w_last_bit);

    assign ready_to_load = r_rdy;
    assign ready_to_send = r_rdy;

    neo_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_enc (
        .clock    (clock),
        .reset    (reset),
        .start    (w_enc_start),
        .bit_val  (w_bit_val),
        .line     (neo_data),
        .bit_done (w_bit_done)
    );

    // Colour storage: written only by accepted loads, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_load_ok) begin
            r_mem[w_wr_addr] <= color_level;
        end
    end

    // Frame sequencer: IDLE -> SEND (bit counting) -> LATCH (low gap) -> IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rdy     <= 1'b1;
            r_bit_idx <= '0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (send_it) begin
                        r_state   <= SEND;
                        r_rdy     <= 1'b0;
                        r_bit_idx <= '0;
                    end
                end
                SEND: begin
                    if (w_bit_done) begin
                        if (w_last_bit) begin
                            r_state   <= LATCH;
                            r_lat_cnt <= '0;
                        end else begin
                            r_bit_idx <= w_nxt_idx;
                        end
                    end
                end
                LATCH: begin
                    if (r_lat_cnt == LW'(TRESET_CYC - 1)) begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule
